// File: rtl/mole_scheduler_pkg.sv
// mole_pkg: shared states, constants and helpers for the mole scheduler
package mole_pkg;
    typedef enum logic [1:0] {IDLE, PICK, GAP, UP} state_t;
    localparam logic [3:0] NO_HOLE = 4'hF;
    localparam int NUM_HOLES = 9;
    localparam int GAP_BASE_MS = 100;
    localparam int GAP_STEP_MS = 16;
    function automatic logic [NUM_HOLES-1:0] onehot(input logic [3:0] idx);
        return NUM_HOLES'(1) << idx;
    endfunction
endpackage

// File: rtl/mole_scheduler_if.sv
// mole_if: game-side signals between the scheduler and its neighbours
interface mole_if #(parameter int NUM_HOLES = mole_pkg::NUM_HOLES);
    logic                 enable;
    logic [8:0]           rand_num;
    logic [NUM_HOLES-1:0] hit_btn;
    logic [11:0]          up_time_ms;
    logic [NUM_HOLES-1:0] mole_oh;
    logic [3:0]           hole_idx;
    logic                 hit_pulse;
    logic                 miss_pulse;
    logic                 busy;
    modport master (output enable, rand_num, hit_btn, up_time_ms,
                    input mole_oh, hole_idx, hit_pulse, miss_pulse, busy);
    modport slave (input enable, rand_num, hit_btn, up_time_ms,
                   output mole_oh, hole_idx, hit_pulse, miss_pulse, busy);
endinterface

// File: rtl/mole_scheduler_ms_timer.sv
// ms_timer: prescaled millisecond counter; done flags the cycle that completes target_ms
module ms_timer #(
    parameter int TICKS_PER_MS = 1000
) (
    input  logic        clk_1mhz,
    input  logic        rst,
    input  logic        clear,
    input  logic [11:0] target_ms,
    output logic        done
);
    localparam int PW = TICKS_PER_MS > 1 ? $clog2(TICKS_PER_MS) : 1;
    logic [PW-1:0] presc_q;
    logic [11:0]   ms_q;
    logic          ms_tick;
    assign ms_tick = presc_q == PW'(TICKS_PER_MS - 1);
    // done fires in the last cycle so the owner leaves after exactly target_ms*TICKS_PER_MS cycles
    assign done = ms_tick && ms_q == target_ms - 12'd1;
    // prescaler and ms counter, both restarted on every state entry
    always_ff @(posedge clk_1mhz or posedge rst) begin
        if (rst || clear) begin
            presc_q <= '0;
            ms_q    <= '0;
        end else begin
            presc_q <= ms_tick ? '0 : presc_q + PW'(1);
            ms_q    <= ms_tick ? ms_q + 12'd1 : ms_q;
        end
    end
endmodule

// File: rtl/mole_scheduler.sv
// mole_scheduler: picks a hole and gap from the LFSR, raises the mole, reports hit or miss
module mole_scheduler #(
    parameter int NUM_HOLES    = mole_pkg::NUM_HOLES,
    parameter int TICKS_PER_MS = 1000,
    parameter int GAP_BASE_MS  = mole_pkg::GAP_BASE_MS,
    parameter int GAP_STEP_MS  = mole_pkg::GAP_STEP_MS,
    parameter int RETRY_MAX    = 16
) (
    input logic   clk_1mhz,
    input logic   rst,
    mole_if.slave bus
);
    import mole_pkg::*;
    localparam int RW = $clog2(RETRY_MAX + 1);
    localparam logic [4:0] NH = 5'(NUM_HOLES);
    state_t               state_q, state_d;
    logic [3:0]           hole_q, hole_d, last_q, last_d, cand, fb;
    logic [11:0]          gap_q, gap_d, up_q, up_d;
    logic [RW-1:0]        retry_q, retry_d;
    logic [NUM_HOLES-1:0] mole_q, mole_d;
    logic                 hit_q, hit_d, miss_q, miss_d, done, accept, fallback;
    assign cand     = bus.rand_num[3:0];
    assign accept   = {1'b0, cand} < NH && cand != last_q;
    assign fallback = retry_q >= RW'(RETRY_MAX);
    assign fb       = (last_q == NO_HOLE || {1'b0, last_q} + 5'd1 == NH) ? 4'd0 : last_q + 4'd1;
    ms_timer #(.TICKS_PER_MS(TICKS_PER_MS)) u_timer (
        .clk_1mhz (clk_1mhz),
        .rst      (rst),
        .clear    (state_d != state_q || state_q == IDLE),
        .target_ms(state_q == GAP ? gap_q : up_q),
        .done     (done)
    );
    // next-state and round bookkeeping; enable low overrides everything but keeps last_hole
    always_comb begin
        state_d = state_q;
        hole_d  = hole_q;
        last_d  = last_q;
        gap_d   = gap_q;
        up_d    = up_q;
        retry_d = retry_q;
        mole_d  = mole_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        if (!bus.enable) begin
            state_d = IDLE;
            mole_d  = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = PICK;
                    mole_d  = '0;
                end
                PICK: begin
                    if (accept || fallback) begin
                        hole_d  = accept ? cand : fb;
                        last_d  = accept ? cand : fb;
                        gap_d   = 12'(GAP_BASE_MS) + 12'(GAP_STEP_MS) * {7'd0, bus.rand_num[8:4]};
                        retry_d = '0;
                        state_d = GAP;
                    end else begin
                        retry_d = retry_q + RW'(1);
                    end
                end
                GAP: begin
                    if (done) begin
                        state_d = UP;
                        mole_d  = NUM_HOLES'(onehot(hole_q));
                        up_d    = bus.up_time_ms == 12'd0 ? 12'd1 : bus.up_time_ms;
                    end
                end
                UP: begin
                    if (bus.hit_btn[hole_q] || done) begin
                        hit_d   = bus.hit_btn[hole_q];
                        miss_d  = !bus.hit_btn[hole_q];
                        mole_d  = '0;
                        state_d = PICK;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
    // state and output registers with asynchronous reset
    always_ff @(posedge clk_1mhz or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hole_q  <= '0;
            last_q  <= NO_HOLE;
            gap_q   <= '0;
            up_q    <= 12'd1;
            retry_q <= '0;
            mole_q  <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hole_q  <= hole_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
            up_q    <= up_d;
            retry_q <= retry_d;
            mole_q  <= mole_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end
    assign bus.mole_oh    = mole_q;
    assign bus.hole_idx   = hole_q;
    assign bus.hit_pulse  = hit_q;
    assign bus.miss_pulse = miss_q;
    assign bus.busy       = state_q != IDLE;
endmodule

// File: doc/mole_scheduler.md
Name: mole_scheduler

Overview:
- Sequences one whack-a-mole round at a time using the 9-bit LFSR output of the game's random generator.
- Picks the target hole and the random idle gap before the mole appears.
- Raises the mole on a 3x3 hole array, then reports a hit or a miss for each round.
- Sits between the random generator and the score/LED logic, on the 1 MHz game clock.

Parameters:
- NUM_HOLES, 9: number of holes. Legal range 2..16.
- TICKS_PER_MS, 1000: clk_1mhz cycles per millisecond. Set to 4 in simulation.
- GAP_BASE_MS, 100: minimum gap before the mole rises.
- GAP_STEP_MS, 16: gap increment per unit of the random gap field.
- RETRY_MAX, 16: PICK cycles allowed before the forced fallback.

Ports:
- clk_1mhz  in  1  game clock
- rst  in  1  reset; asynchronous, active-high
- enable  in  1  run the game; low forces IDLE
- rand_num  in  9  random generator output; changes every clock
- hit_btn  in  NUM_HOLES  debounced, one-cycle-per-press, one-hot button pulses
- up_time_ms  in  12  how long the mole stays up; sampled on UP entry
- mole_oh  out  NUM_HOLES  one-hot raised mole, registered
- hole_idx  out  4  index of the current or last hole
- hit_pulse  out  1  one cycle per successful hit
- miss_pulse  out  1  one cycle per timeout
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: clk_1mhz clock; rst is asynchronous and active-high.
- Reset values:
  - state=IDLE; mole_oh=0; hole_idx=0; hit_pulse=0; miss_pulse=0; busy=0.
  - last_hole=4'hF (meaning none); retry counter=0; ms timer cleared.
- States: IDLE, PICK, GAP, UP.
- IDLE:
  - mole_oh=0.
  - enable=1 moves to PICK on the next edge.
- PICK, one evaluation per cycle:
  - cand = rand_num[3:0].
  - Accept if cand < NUM_HOLES and cand != last_hole.
  - Fallback: after RETRY_MAX consecutive rejects, accept (last_hole+1) mod NUM_HOLES. If last_hole=4'hF, accept 0. This covers a stuck or all-zero LFSR.
  - On accept, in the same cycle: hole_idx<=cand, last_hole<=cand, gap_ms<=GAP_BASE_MS+GAP_STEP_MS*rand_num[8:4]; move to GAP; clear the retry counter. On fallback, use the gap field sampled in that same cycle.
  - Gap range with defaults: 100..596 ms; gap_ms register is 12 bits.
- GAP:
  - The ms timer restarts on entry.
  - After exactly gap_ms*TICKS_PER_MS cycles in GAP, move to UP.
  - mole_oh becomes (1<<hole_idx) on that same edge.
- UP:
  - up_time_ms is latched on entry; a value of 0 is treated as 1. The ms timer restarts.
  - hit_btn[hole_idx]=1: hit_pulse=1 next cycle, mole_oh<=0, move to PICK.
  - Presses on other holes are ignored. Multiple bits set: only bit hole_idx matters.
  - Timer reaches the latched up time (up_ms*TICKS_PER_MS cycles) with no hit: miss_pulse=1 next cycle, mole_oh<=0, move to PICK.
  - Hit and timeout in the same cycle: hit wins, no miss_pulse.
- Pulse outputs:
  - hit_pulse and miss_pulse are registered, exactly one cycle, mutually exclusive.
  - At most one pulse per round.
- enable deasserted in any state:
  - Next edge: IDLE, mole_oh=0, timer cleared, no pulse generated.
  - last_hole is kept.
  - Re-enable restarts at PICK.
- rst mid-round: all outputs go to reset values immediately, asynchronously.
- Timer: prescaler 0..TICKS_PER_MS-1 plus a 12-bit ms counter. Both clear on every state entry, so durations are exact with no phase carry-over.

Decomposition:
- Package mole_pkg holds:
  - state enum (IDLE/PICK/GAP/UP);
  - NO_HOLE=4'hF;
  - default NUM_HOLES, GAP_BASE_MS, GAP_STEP_MS;
  - a function onehot(idx) returning NUM_HOLES bits.
- Sub-module ms_timer holds the prescaler and ms counter.
  - Inputs: clk_1mhz, rst, clear, target_ms.
  - Output: done, a level asserted when the elapsed ms equals target_ms.
  - Instantiated once; the FSM drives clear on each state change.

Test Plan (TICKS_PER_MS=4):
- Basic gap and timeout:
  - Stimulus: reset, enable=1, rand_num held 9'h023, up_time_ms=5.
  - Response: accept hole 3 with gap 132 ms. mole_oh=9'h008 exactly 528 cycles after GAP entry. It stays 20 cycles, then miss_pulse for 1 cycle and mole_oh=0.
- Hit, wrong press and repeat rejection:
  - Stimulus: as above, then hit_btn=9'h008 on the 3rd UP cycle; rand_num still 9'h023.
  - Response: hit_pulse for 1 cycle, no miss_pulse. Next PICK rejects hole 3 (repeat).
  - Stimulus: a wrong press hit_btn=9'h001 during UP.
  - Response: ignored.
- Rejection fallback:
  - Stimulus: rand_num held 9'h00F.
  - Response: 16 rejects, then fallback accepts hole 0 (last_hole=none) with gap 100 ms.
  - Stimulus: rand_num held 9'h000 afterwards.
  - Response: fallback picks hole 1.
- Hit/timeout collision:
  - Stimulus: hit_btn[hole] on the exact cycle the up-timer expires.
  - Response: hit_pulse=1, miss_pulse=0.
- Enable drop:
  - Stimulus: enable=0 during UP.
  - Response: next cycle IDLE, mole_oh=0, busy=0, no pulse.
  - Stimulus: re-enable.
  - Response: PICK on the next edge.
- Async reset:
  - Stimulus: rst asserted mid-GAP between clock edges.
  - Response: all outputs 0 before the next edge, last_hole=4'hF.
  - Stimulus: up_time_ms=0.
  - Response: mole up exactly 4 cycles.
